// File: rtl/irq_ctrl_if.sv
// Bundle of the interrupt controller's line, core-boundary and request
// signals. The slave side is the controller, the master side is its environment.
interface irq_ctrl_if #(
  parameter int NIRQ = 8
);
  logic [NIRQ-1:0] irq_in;
  logic [NIRQ-1:0] irq_mask;
  logic            ie;
  logic            enable_pc;
  logic [11:0]     opcode;
  logic [31:0]     pc;
  logic            irr;
  logic [31:0]     irr_dest;
  logic [31:0]     irr_ret;
  logic [4:0]      irq_id;
  logic            in_isr;
  logic [NIRQ-1:0] pending;

  modport master (
    output irq_in, irq_mask, ie, enable_pc, opcode, pc,
    input  irr, irr_dest, irr_ret, irq_id, in_isr, pending
  );

  modport slave (
    input  irq_in, irq_mask, ie, enable_pc, opcode, pc,
    output irr, irr_dest, irr_ret, irq_id, in_isr, pending
  );
endinterface

// File: rtl/irq_ctrl.sv
// Edge-triggered, non-nesting interrupt controller. Rising edges on irq_in
// latch pending bits; the lowest enabled pending line is requested from the
// core's PC logic, accepted at the next instruction boundary and served until
// the handler executes RETIRQ.
module irq_ctrl #(
  parameter int          NIRQ          = 8,
  parameter logic [31:0] VECTOR_BASE   = 32'h0000_0100,
  parameter logic [31:0] VECTOR_STRIDE = 32'd4
) (
  input logic         clk,
  input logic         rst,
  irq_ctrl_if.slave   bus
);

  localparam logic [11:0] RETIRQ = 12'b0011_1001_1000;

  typedef enum logic [1:0] {IDLE, REQ, ISR} state_t;

  state_t          state;
  logic [NIRQ-1:0] prev;
  logic [NIRQ-1:0] pending_q;
  logic [NIRQ-1:0] rise;
  logic [NIRQ-1:0] masked;
  logic [NIRQ-1:0] clr_mask;
  logic [4:0]      lowest_idx;

  // Rising-edge detect and the set of lines eligible for service.
  always_comb begin
    rise   = bus.irq_in & ~prev;
    masked = pending_q & bus.irq_mask;
  end

  // Lowest eligible line wins; scanning downwards leaves the lowest index last.
  always_comb begin
    // NOTE: the default before the loop keeps this purely combinational;
    // without it the no-match path would infer a latch.
    lowest_idx = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (masked[i]) lowest_idx = 5'(i);
    end
  end

  // Pending bit of the line being accepted is cleared at the REQ->ISR edge.
  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < NIRQ; i++) begin
      clr_mask[i] = (state == REQ) && bus.enable_pc && (bus.irq_id == 5'(i));
    end
  end

  assign bus.pending = pending_q;

  // Request/serve FSM with registered outputs, plus edge and pending registers.
  always_ff @(posedge clk) begin
    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    prev <= bus.irq_in;
    if (!rst) begin
      state        <= IDLE;
      bus.irr      <= 1'b0;
      bus.in_isr   <= 1'b0;
      pending_q    <= '0;
      bus.irq_id   <= '0;
      bus.irr_dest <= VECTOR_BASE;
      bus.irr_ret  <= '0;
    end else begin
      // A fresh edge overrides a coincident clear so no interrupt is lost.
      pending_q <= (pending_q & ~clr_mask) | rise;
      case (state)
        IDLE: begin
          if (bus.ie && (|masked)) begin
            state        <= REQ;
            bus.irr      <= 1'b1;
            bus.irq_id   <= lowest_idx;
            bus.irr_dest <= VECTOR_BASE + VECTOR_STRIDE * {27'd0, lowest_idx};
          end
        end
        REQ: begin
          // Request is frozen here until the core takes it at a boundary.
          if (bus.enable_pc) begin
            state       <= ISR;
            bus.irr     <= 1'b0;
            bus.in_isr  <= 1'b1;
            bus.irr_ret <= bus.pc;
          end
        end
        ISR: begin
          if (bus.enable_pc && (bus.opcode == RETIRQ)) begin
            state      <= IDLE;
            bus.in_isr <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          bus.irr    <= 1'b0;
          bus.in_isr <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios for the documented
// corner cases followed by randomized traffic, all compared every cycle
// against a behavioural model of the controller.
module tb_irq_ctrl;

  localparam int          NIRQ   = 8;
  localparam logic [31:0] VBASE  = 32'h0000_0100;
  localparam logic [31:0] VSTEP  = 32'd4;
  localparam logic [11:0] RETIRQ = 12'h398;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  irq_ctrl_if #(.NIRQ(NIRQ)) bus ();

  irq_ctrl #(
    .NIRQ          (NIRQ),
    .VECTOR_BASE   (VBASE),
    .VECTOR_STRIDE (VSTEP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: what the controller is doing, in plain terms.
  logic [NIRQ-1:0] m_pending;
  logic [NIRQ-1:0] m_last_in;
  bit              m_requesting;
  bit              m_in_handler;
  int              m_line;
  logic [31:0]     m_dest;
  logic [31:0]     m_ret;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs now applied.
  task automatic model_step();
    logic [NIRQ-1:0] edges;
    logic [NIRQ-1:0] eligible;
    int              first;
    if (!rst) begin
      m_pending    = '0;
      m_requesting = 0;
      m_in_handler = 0;
      m_line       = 0;
      m_dest       = VBASE;
      m_ret        = 0;
      m_last_in    = bus.irq_in;
      return;
    end
    edges    = bus.irq_in & ~m_last_in;
    eligible = m_pending & bus.irq_mask;
    if (m_requesting) begin
      if (bus.enable_pc) begin
        m_ret               = bus.pc;
        m_pending[m_line]   = 1'b0;
        m_requesting        = 0;
        m_in_handler        = 1;
      end
    end else if (m_in_handler) begin
      if (bus.enable_pc && bus.opcode == RETIRQ) m_in_handler = 0;
    end else if (bus.ie && eligible != 0) begin
      first = -1;
      for (int i = 0; i < NIRQ; i++) begin
        if (eligible[i] && first < 0) first = i;
      end
      m_line       = first;
      m_dest       = VBASE + 32'(first) * VSTEP;
      m_requesting = 1;
    end
    m_pending = m_pending | edges;
    m_last_in = bus.irq_in;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("irr",      32'(bus.irr),      32'(m_requesting));
    check("in_isr",   32'(bus.in_isr),   32'(m_in_handler));
    check("irq_id",   32'(bus.irq_id),   32'(m_line));
    check("irr_dest", bus.irr_dest,      m_dest);
    check("irr_ret",  bus.irr_ret,       m_ret);
    check("pending",  32'(bus.pending),  32'(m_pending));
  endtask

  initial begin
    rst           = 1'b0;
    bus.irq_in    = '0;
    bus.irq_mask  = '1;
    bus.ie        = 1'b1;
    bus.enable_pc = 1'b0;
    bus.opcode    = 12'h000;
    bus.pc        = 32'h0000_0040;

    // Reset values.
    tick();
    tick();
    check("rst_irr_dest", bus.irr_dest, 32'h0000_0100);
    check("rst_pending",  32'(bus.pending), 32'h0);
    rst = 1'b1;
    tick();

    // Single request on line 2: irr two edges after the input edge.
    bus.irq_in[2] = 1'b1;
    tick();
    check("single_pend", 32'(bus.pending[2]), 32'h1);
    check("single_irr_early", 32'(bus.irr), 32'h0);
    tick();
    check("single_irr",  32'(bus.irr), 32'h1);
    check("single_dest", bus.irr_dest, 32'h0000_0108);
    check("single_id",   32'(bus.irq_id), 32'h2);
    bus.irq_in    = '0;
    bus.enable_pc = 1'b1;
    tick();
    check("accept_ret",  bus.irr_ret, 32'h0000_0040);
    check("accept_isr",  32'(bus.in_isr), 32'h1);
    check("accept_clr",  32'(bus.pending[2]), 32'h0);
    bus.opcode = RETIRQ;
    tick();
    bus.enable_pc = 1'b0;
    bus.opcode    = 12'h000;

    // Priority and freeze: lines 5 and 3 together, then line 0 during REQ.
    bus.irq_in = 8'h28;
    tick();
    tick();
    check("prio_id",   32'(bus.irq_id), 32'h3);
    check("prio_dest", bus.irr_dest, 32'h0000_010C);
    bus.irq_in = 8'h29;
    bus.ie     = 1'b0;
    tick();
    check("freeze_dest", bus.irr_dest, 32'h0000_010C);
    check("freeze_irr",  32'(bus.irr), 32'h1);
    check("freeze_p0",   32'(bus.pending[0]), 32'h1);
    bus.ie        = 1'b1;
    bus.irq_in    = '0;
    bus.pc        = 32'h0000_0200;
    bus.enable_pc = 1'b1;
    tick();                      // accept line 3
    bus.opcode = RETIRQ;
    tick();                      // return
    bus.opcode    = 12'h000;
    bus.enable_pc = 1'b0;
    tick();                      // request line 0
    check("line0_id", 32'(bus.irq_id), 32'h0);
    bus.enable_pc = 1'b1;
    tick();                      // accept line 0, only line 5 pending

    // Return and re-arm on line 5.
    bus.opcode = RETIRQ;
    tick();
    check("ret_isr", 32'(bus.in_isr), 32'h0);
    bus.enable_pc = 1'b0;
    bus.opcode    = 12'h000;
    tick();
    check("rearm_irr", 32'(bus.irr), 32'h1);
    check("rearm_id",  32'(bus.irq_id), 32'h5);
    bus.enable_pc = 1'b1;
    tick();
    bus.opcode = RETIRQ;
    bus.ie     = 1'b0;
    tick();
    bus.enable_pc = 1'b0;
    bus.opcode    = 12'h000;

    // Masking of line 4 by ie and by irq_mask.
    bus.irq_in[4] = 1'b1;
    tick();
    tick();
    check("mask_ie", 32'(bus.irr), 32'h0);
    bus.ie       = 1'b1;
    bus.irq_mask = 8'hEF;
    tick();
    check("mask_bit", 32'(bus.irr), 32'h0);
    bus.irq_mask = 8'hFF;
    tick();
    check("mask_open", 32'(bus.irr), 32'h1);
    check("mask_id",   32'(bus.irq_id), 32'h4);

    // Set/clear collision on line 4.
    bus.irq_in[4] = 1'b0;
    tick();
    bus.irq_in[4] = 1'b1;
    bus.enable_pc = 1'b1;
    bus.pc        = 32'h0000_1234;
    tick();
    check("collide_pend", 32'(bus.pending[4]), 32'h1);
    check("collide_ret",  bus.irr_ret, 32'h0000_1234);
    bus.enable_pc = 1'b0;

    // Reset while in ISR, line 1 held high across release.
    rst           = 1'b0;
    bus.irq_in    = 8'h02;
    bus.enable_pc = 1'b1;
    bus.pc        = 32'h0000_0999;
    tick();
    check("rst_isr_isr",  32'(bus.in_isr), 32'h0);
    check("rst_isr_ret",  bus.irr_ret, 32'h0);
    check("rst_isr_dest", bus.irr_dest, 32'h0000_0100);
    bus.enable_pc = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    tick();
    check("held_pend", 32'(bus.pending), 32'h0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      bus.irq_in    = bus.irq_in ^ NIRQ'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 19) == 0) bus.irq_mask = NIRQ'($urandom);
      bus.ie        = ($urandom_range(0, 9) != 0);
      bus.enable_pc = ($urandom_range(0, 2) == 0);
      bus.opcode    = ($urandom_range(0, 2) == 0) ? RETIRQ : 12'($urandom);
      bus.pc        = $urandom;
      rst           = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
